// File: rtl/keypad_emulator_if.sv
// Key-entry handshake between a key source (master) and the keypad emulator (slave).
interface keypad_emulator_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;

  modport master (output key_valid, output key_code, input key_ready);
  modport slave  (input key_valid, input key_code, output key_ready);
endinterface

// File: rtl/keypad_emulator.sv
// 4x4 keypad model: presses each accepted key for HOLD_CYCLES, releases for GAP_CYCLES,
// and answers the scanner's active-low column drive on the matching active-low row.
module keypad_emulator #(
  parameter int HOLD_CYCLES = 1000000,
  parameter int GAP_CYCLES  = 1000000,
  parameter int ROW_LAT     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  keypad_emulator_if.slave  key_bus,
  input  logic [3:0]        Col,
  output logic [3:0]        Row,
  output logic              pressed,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [23:0] HOLD_LAST = 24'(HOLD_CYCLES - 1);
  localparam logic [23:0] GAP_LAST  = 24'(GAP_CYCLES - 1);

  state_t      state;
  state_t      state_next;
  logic [23:0] counter;
  logic [23:0] counter_next;
  logic [3:0]  key;
  logic [3:0]  key_next;
  logic        done_next;
  logic        ready;
  logic        match;
  logic [3:0]  row_next;
  logic [3:0]  row_pipe [ROW_LAT];

  // Col bit that drives the column holding this key (bit3 = C1 .. bit0 = C4).
  function automatic logic [1:0] col_bit(input logic [3:0] k);
    case (k)
      4'h1, 4'h4, 4'h7, 4'h0: col_bit = 2'd3;
      4'h2, 4'h5, 4'h8, 4'hF: col_bit = 2'd2;
      4'h3, 4'h6, 4'h9, 4'hE: col_bit = 2'd1;
      default:                col_bit = 2'd0;
    endcase
  endfunction

  // Active-low row line on which this key sits.
  function automatic logic [3:0] row_pattern(input logic [3:0] k);
    case (k)
      4'h1, 4'h2, 4'h3, 4'hA: row_pattern = 4'b0111;
      4'h4, 4'h5, 4'h6, 4'hB: row_pattern = 4'b1011;
      4'h7, 4'h8, 4'h9, 4'hC: row_pattern = 4'b1101;
      default:                row_pattern = 4'b1110;
    endcase
  endfunction

  assign key_bus.key_ready = ready;

  // Next-state, counter and key-latch logic of the press/release sequencer.
  always_comb begin
    state_next   = state;
    counter_next = counter;
    key_next     = key;
    done_next    = 1'b0;
    case (state)
      IDLE: begin
        if (key_bus.key_valid && ready) begin
          key_next     = key_bus.key_code;
          counter_next = 24'd0;
          state_next   = PRESS;
        end else begin
          state_next   = IDLE;
        end
      end
      PRESS: begin
        if (counter == HOLD_LAST) begin
          counter_next = 24'd0;
          state_next   = GAP;
        end else begin
          counter_next = counter + 24'd1;
        end
      end
      GAP: begin
        if (counter == GAP_LAST) begin
          counter_next = 24'd0;
          state_next   = IDLE;
          done_next    = 1'b1;
        end else begin
          counter_next = counter + 24'd1;
        end
      end
      default: begin
        counter_next = 24'd0;
        state_next   = IDLE;
      end
    endcase
  end

  // Sequencer state plus outputs registered from the next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      counter <= 24'd0;
      key     <= 4'h0;
      ready   <= 1'b1;
      pressed <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      counter <= counter_next;
      key     <= key_next;
      ready   <= (state_next == IDLE);
      pressed <= (state_next == PRESS);
      done    <= done_next;
    end
  end

  // Each column bit is tested on its own, so several low columns still register a hit.
  assign match    = pressed && (Col[col_bit(key)] == 1'b0);
  assign row_next = match ? row_pattern(key) : 4'b1111;

  // Row response delay line; the last stage drives Row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROW_LAT; i++) begin
        row_pipe[i] <= 4'b1111;
      end
    end else begin
      row_pipe[0] <= row_next;
      for (int i = 1; i < ROW_LAT; i++) begin
        row_pipe[i] <= row_pipe[i-1];
      end
    end
  end

  assign Row = row_pipe[ROW_LAT-1];

endmodule
